// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detectors.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; a clear coinciding with a match restarts at one.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

  assign sat = &count;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: Moore detect pulse plus saturating match count.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] hist_p0, hist_n, hist_shift;
  logic [LEN_W-1:0]   fill_p0, fill_n;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q, len_clamp;
  logic               ovl_q;
  logic [MAX_LEN-1:0] mask;
  logic               full, hit_p0;

  assign len_clamp  = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
  assign hist_shift = MAX_LEN'({hist_p0, in});
  assign full       = ({1'b0, fill_p0} + (LEN_W+1)'(1)) >= {1'b0, len_q};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // Stage 0: sample, compare and next-state
  always_comb begin
    state_n = state;
    hist_n  = hist_p0;
    fill_n  = fill_p0;
    hit_p0  = 1'b0;
    if (cfg_load) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = (len_clamp != '0) ? FILL : IDLE;
    end else if (en && state != IDLE) begin
      hist_n = hist_shift;
      hit_p0 = full && (((hist_shift ^ pat_q) & mask) == '0);
      if (hit_p0 && !ovl_q) begin
        fill_n  = '0;
        state_n = FILL;
      end else if (full) begin
        fill_n  = len_q;
        state_n = ARMED;
      end else begin
        fill_n  = fill_p0 + LEN_W'(1);
        state_n = FILL;
      end
    end
  end

  // Stage 1: registered state and Moore detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hist_p0 <= '0;
      fill_p0 <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      detect  <= 1'b0;
    end else begin
      state   <= state_n;
      hist_p0 <= hist_n;
      fill_p0 <= fill_n;
      detect  <= hit_p0;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamp;
        ovl_q <= cfg_overlap;
      end
    end
  end

  seq_match_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (hit_p0),
    .count(match_count),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: directed bit streams on two detector instances (8-bit and 2-bit counters).
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic a_en, a_in, a_ld, a_clr, a_det, a_sat;
  logic [7:0] a_cnt;
  logic b_en, b_in, b_ld, b_clr, b_det, b_sat;
  logic [1:0] b_cnt;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [MAX_LEN-1:0] pend_pat;
  logic [LEN_W-1:0]   pend_len;
  logic               pend_ovl;

  typedef struct {
    int sel;
    int stp;
    bit det;
    int cnt;
    bit sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;
  int a_exp   = 0;
  int b_exp   = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .in(a_in), .cfg_load(a_ld),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(a_clr), .detect(a_det), .match_count(a_cnt), .cnt_sat(a_sat)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .in(b_in), .cfg_load(b_ld),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(b_clr), .detect(b_det), .match_count(b_cnt), .cnt_sat(b_sat)
  );

  task automatic check(input string name, input int stp, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, stp, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per stimulus edge, checked just after that edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.sel == 0) begin
        check("a_detect", mon_e.stp, int'(a_det), int'(mon_e.det));
        check("a_count",  mon_e.stp, int'(a_cnt), mon_e.cnt);
        check("a_sat",    mon_e.stp, int'(a_sat), int'(mon_e.sat));
      end else begin
        check("b_detect", mon_e.stp, int'(b_det), int'(mon_e.det));
        check("b_count",  mon_e.stp, int'(b_cnt), mon_e.cnt);
        check("b_sat",    mon_e.stp, int'(b_sat), int'(mon_e.sat));
      end
    end
  end

  task automatic step(input int sel, input bit e, input bit b, input bit ld, input bit clr, input bit d);
    exp_t x;
    @(negedge clk);
    cfg_pattern = pend_pat;
    cfg_len     = pend_len;
    cfg_overlap = pend_ovl;
    a_en  = (sel == 0) && e;
    a_in  = b;
    a_ld  = (sel == 0) && ld;
    a_clr = (sel == 0) && clr;
    b_en  = (sel == 1) && e;
    b_in  = b;
    b_ld  = (sel == 1) && ld;
    b_clr = (sel == 1) && clr;
    x.sel = sel;
    x.stp = step_no;
    x.det = d;
    if (sel == 0) begin
      if (clr) a_exp = d ? 1 : 0;
      else if (d && a_exp < 255) a_exp++;
      x.cnt = a_exp;
      x.sat = (a_exp == 255);
    end else begin
      if (clr) b_exp = d ? 1 : 0;
      else if (d && b_exp < 3) b_exp++;
      x.cnt = b_exp;
      x.sat = (b_exp == 3);
    end
    sb.push_back(x);
    step_no++;
    @(posedge clk);
  endtask

  task automatic load(input int sel, input logic [7:0] p, input logic [3:0] l, input bit o);
    pend_pat = p;
    pend_len = l;
    pend_ovl = o;
    step(sel, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // '1'/'0' = sampled bit, '-' = en low; exp char '1' = detect expected after that edge
  task automatic stream(input int sel, input string bits, input string exp);
    for (int i = 0; i < bits.len(); i++) begin
      logic [7:0] c;
      c = bits.getc(i);
      step(sel, c != "-", c == "1", 1'b0, 1'b0, exp.getc(i) == "1");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a_en, a_in, a_ld, a_clr, b_en, b_in, b_ld, b_clr} = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    pend_pat = '0; pend_len = '0; pend_ovl = 1'b0;
    #12;
    check("reset_a_detect", -1, int'(a_det), 0);
    check("reset_a_count",  -1, int'(a_cnt), 0);
    check("reset_a_sat",    -1, int'(a_sat), 0);
    check("reset_b_count",  -1, int'(b_cnt), 0);
    #10 rst_n = 1'b1;

    load(0, 8'b0011_0110, 4'd6, 1'b1);
    stream(0, "110110110110", "000001001001");
    load(0, 8'b0011_0110, 4'd6, 1'b0);
    stream(0, "110110110110", "000001000001");
    load(0, 8'b0011_0110, 4'd6, 1'b1);
    stream(0, "11010110---110-", "000000000000010");
    load(0, 8'hAB, 4'd0, 1'b1);
    stream(0, "11111111", "00000000");
    load(0, 8'hFF, 4'd12, 1'b1);
    stream(0, "111111111", "000000011");

    load(1, 8'h01, 4'd1, 1'b1);
    stream(1, "11111", "11111");
    step(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    stream(1, "0", "0");
    step(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    stream(0, "1", "1");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a_detect", step_no, int'(a_det), 0);
    check("async_rst_a_count",  step_no, int'(a_cnt), 0);
    check("async_rst_a_sat",    step_no, int'(a_sat), 0);
    check("async_rst_b_count",  step_no, int'(b_cnt), 0);
    {a_en, a_in, a_ld, a_clr, b_en, b_in, b_ld, b_clr} = '0;
    a_exp = 0;
    b_exp = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    stream(0, "11111111", "00000000");
    load(0, 8'h01, 4'd1, 1'b1);
    stream(0, "1", "1");

    @(negedge clk);
    {a_en, a_in, a_ld, a_clr, b_en, b_in, b_ld, b_clr} = '0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", step_no, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the fixed-pattern Moore detectors in the FSM library.
- Pattern, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config strobe.
- Output is a registered Moore detect pulse plus a saturating match counter.
- Sits on serial framing/sync paths, between a bit-serial receiver and the frame-alignment logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  sample enable; in sampled only when en=1
in  in  1  serial input bit
cfg_load  in  1  latch cfg_* and restart search
cfg_pattern  in  MAX_LEN  pattern; first-received bit = bit [len-1], last = bit [0]
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count
detect  out  1  registered match pulse (Moore)
match_count  out  CNT_W  saturating count of matches
cnt_sat  out  1  match_count at all-ones

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE; history, fill count and latched config all zero; detect=0, match_count=0, cnt_sat=0.
  - Latched len=0, so the block is disabled until the first cfg_load.
- Config load:
  - On a cfg_load edge, latch pattern, len and overlap.
  - Clear history and fill count; detect<=0. in is ignored that cycle.
  - match_count is not cleared.
  - Next state: FILL if latched len!=0, else IDLE.
- Length rules:
  - cfg_len=0 is latched as 0 and disables the block (stays in IDLE).
  - cfg_len>MAX_LEN is latched as MAX_LEN.
- FSM states:
  - IDLE: no detection. Leaves only via cfg_load with nonzero len.
  - FILL: fewer than len valid bits held. Each en=1 edge shifts in and increments fill; moves to ARMED when fill reaches len.
  - ARMED: at least len valid bits held; compare on every en=1 edge.
- Sampling and compare:
  - On each en=1 edge: history <= {history[MAX_LEN-2:0], in}.
  - Match = (fill+1 >= len) and new history[len-1:0] == pattern[len-1:0]. Bits above len are masked.
- Detect timing:
  - detect <= match, registered.
  - detect is high for the cycle following the edge that sampled the last pattern bit.
  - Consecutive matches give consecutive high cycles, e.g. pattern 11 in overlap mode with input 111 gives detect high for 2 cycles.
- Overlap mode: history is kept after a match, and state stays ARMED.
- Non-overlap mode: on a match, fill is cleared and state goes to FILL, so the next match needs len fresh bits.
- en=0: history, fill and state hold; detect<=0.
- Match counter:
  - Increments on every match and saturates at 2^CNT_W-1; cnt_sat is combinational from match_count.
  - If cnt_clr and a match occur on the same edge, match_count<=1.
- Precedence when events coincide on one edge: cfg_load > sample. cnt_clr acts independently of cfg_load.
- Reset mid-stream: everything returns to reset values immediately, including a high detect.
- Latency: 1 cycle from the sampling edge of the final bit to detect.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, FILL, ARMED) and a length-clamp function.
- One natural sub-module, seq_match_cnt: the saturating counter with clear (CNT_W parameter). Used here and by other detector variants.
- History shift register and compare stay in the top module.

Test Plan:
- MAX_LEN=8, load pattern 6'b110110, len=6, overlap=1; stream 110110110110 -> detect high after bits 6, 9, 12; match_count=3.
- Same pattern, overlap=0; stream 110110110110 -> detect only after bits 6 and 12; match_count=2.
- len=6, stream 1101 0 110110 with en=0 for 3 cycles inserted mid-pattern -> held bits are not lost; detect after the final 0; detect low in every en=0 cycle.
- cfg_len=0 load, then stream 11111111 -> detect never asserts, state IDLE. Then cfg_len=12 with pattern 8'hFF -> clamped to 8; stream eight 1s -> detect after bit 8.
- CNT_W=2, pattern 1, len=1, overlap=1, stream five 1s -> count 1,2,3,3,3 and cnt_sat=1. Then cnt_clr together with a match -> count=1.
- Assert rst_n=0 asynchronously (between clock edges) while detect=1 mid-stream -> detect and match_count go 0 immediately. After release, no detect until cfg_load.
